// File: rtl/rs_pkg.sv
// Shared types and elaboration-time helpers for the streaming Reed-Solomon encoder.
package rs_pkg;

  localparam int unsigned EGF_ORDER = 4;
  localparam int unsigned EGF_POLY  = 32'h13;
  localparam int unsigned MAX_PAR   = 32;
  localparam int unsigned MAX_W     = 16;

  typedef logic [EGF_ORDER-1:0] symbol_t;
  typedef logic [MAX_PAR-1:0][MAX_W-1:0] coef_arr_t;
  typedef enum logic {MSG, PAR} state_t;

  // Field product; the field order is taken from the top set bit of poly.
  function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                         input int unsigned poly);
    int unsigned order;
    int unsigned acc;
    int unsigned sh;
    order = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (((poly >> k) & 1) != 0) order = k;
    end
    acc = 0;
    sh  = a;
    for (int unsigned k = 0; k < order; k++) begin
      if (((b >> k) & 1) != 0) acc = acc ^ sh;
      sh = sh << 1;
      if (((sh >> order) & 1) != 0) sh = sh ^ poly;
    end
    return acc;
  endfunction

  // Low-order coefficients of prod_{i<par_len} (x - alpha^i), alpha = 2.
  function automatic coef_arr_t gen_poly(input int unsigned par_len, input int unsigned poly);
    int unsigned g [MAX_PAR+1];
    int unsigned root;
    coef_arr_t   res;
    for (int unsigned k = 0; k <= MAX_PAR; k++) g[k] = 0;
    g[0] = 1;
    root = 1;
    for (int unsigned i = 0; i < par_len; i++) begin
      for (int unsigned j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, poly);
      g[0] = gf_mul(g[0], root, poly);
      root = gf_mul(root, 2, poly);
    end
    res = '0;
    for (int unsigned k = 0; k < par_len; k++) res[k] = MAX_W'(g[k]);
    return res;
  endfunction

endpackage

// File: rtl/rs_stream_encoder_gf_const_mul.sv
// Combinational GF(2^W) multiply of a symbol by an elaboration-time constant.
module gf_const_mul #(
  parameter int unsigned W     = 4,
  parameter int unsigned POLY  = 32'h13,
  parameter int unsigned CONST = 1
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y_c
);

  logic [W-1:0] w_acc;
  logic [W-1:0] w_sh;

  // Shift-and-add over the constant's bits, reducing after every shift.
  always_comb begin
    w_acc = '0;
    w_sh  = i_a;
    for (int unsigned k = 0; k < W; k++) begin
      if (((CONST >> k) & 1) != 0) w_acc = w_acc ^ w_sh;
      w_sh = w_sh[W-1] ? ((w_sh << 1) ^ W'(POLY)) : (w_sh << 1);
    end
  end

  assign o_y_c = w_acc;

endmodule

// File: rtl/rs_stream_encoder.sv
// Streaming systematic RS encoder: forwards MSG_LEN symbols, then appends PAR_LEN LFSR parity symbols.
module rs_stream_encoder #(
  parameter int unsigned EGF_ORDER = rs_pkg::EGF_ORDER,
  parameter int unsigned EGF_POLY  = rs_pkg::EGF_POLY,
  parameter int unsigned MSG_LEN   = 4,
  parameter int unsigned PAR_LEN   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EGF_ORDER-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EGF_ORDER-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last
);
  import rs_pkg::*;

  localparam int unsigned W   = EGF_ORDER;
  localparam int unsigned MCW = $clog2(MSG_LEN + 1);
  localparam int unsigned PCW = $clog2(PAR_LEN + 1);
  localparam coef_arr_t   G   = gen_poly(PAR_LEN, EGF_POLY);

  state_t                      r_state, w_state_nxt;
  logic [MCW-1:0]              r_msg_cnt, w_msg_cnt_nxt;
  logic [PCW-1:0]              r_par_cnt, w_par_cnt_nxt;
  logic [PAR_LEN-1:0][W-1:0]   r_par, w_par_nxt;
  logic [PAR_LEN-1:0][W-1:0]   w_prod, w_upd, w_shift;
  logic [W-1:0]                r_out_data, w_out_data_nxt;
  logic                        r_out_valid, w_out_valid_nxt;
  logic                        r_out_first, w_out_first_nxt;
  logic                        r_out_last, w_out_last_nxt;
  logic [W-1:0]                w_fb;
  logic                        w_free;
  logic                        w_in_xfer;

  assign w_fb = in_data ^ r_par[PAR_LEN-1];

  // Feedback taps: one constant multiplier per generator coefficient.
  for (genvar gi = 0; gi < PAR_LEN; gi++) begin : g_tap
    gf_const_mul #(.W(W), .POLY(EGF_POLY), .CONST(32'(G[gi]))) u_mul (
      .i_a  (w_fb),
      .o_y_c(w_prod[gi])
    );
    if (gi == 0) begin : g_lo
      assign w_upd[gi]   = w_prod[gi];
      assign w_shift[gi] = '0;
    end else begin : g_hi
      assign w_upd[gi]   = r_par[gi-1] ^ w_prod[gi];
      assign w_shift[gi] = r_par[gi-1];
    end
  end

  assign w_free    = !r_out_valid || out_ready;
  assign in_ready  = (r_state == MSG) && w_free;
  assign w_in_xfer = in_valid && in_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_msg_cnt_nxt   = r_msg_cnt;
    w_par_cnt_nxt   = r_par_cnt;
    w_par_nxt       = r_par;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_first_nxt = r_out_first;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      MSG: begin
        if (w_in_xfer) begin
          w_out_data_nxt  = in_data;
          w_out_valid_nxt = 1'b1;
          w_out_first_nxt = (r_msg_cnt == '0);
          w_out_last_nxt  = 1'b0;
          w_par_nxt       = w_upd;
          if (r_msg_cnt == MCW'(MSG_LEN - 1)) begin
            w_state_nxt   = PAR;
            w_msg_cnt_nxt = '0;
          end else begin
            w_msg_cnt_nxt = r_msg_cnt + MCW'(1);
          end
        end
      end
      PAR: begin
        if (w_free) begin
          w_out_data_nxt  = r_par[PAR_LEN-1];
          w_out_valid_nxt = 1'b1;
          w_out_first_nxt = 1'b0;
          w_out_last_nxt  = (r_par_cnt == PCW'(PAR_LEN - 1));
          w_par_nxt       = w_shift;
          if (r_par_cnt == PCW'(PAR_LEN - 1)) begin
            w_state_nxt   = MSG;
            w_par_cnt_nxt = '0;
          end else begin
            w_par_cnt_nxt = r_par_cnt + PCW'(1);
          end
        end
      end
      default: w_state_nxt = MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MSG;
      r_msg_cnt   <= '0;
      r_par_cnt   <= '0;
      r_par       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_msg_cnt   <= w_msg_cnt_nxt;
      r_par_cnt   <= w_par_cnt_nxt;
      r_par       <= w_par_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_first <= w_out_first_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule

// File: doc/rs_stream_encoder.md
# rs_stream_encoder

Streaming systematic Reed–Solomon encoder over GF(2^EGF_ORDER). It is the parametrised successor of the block-parallel `encoder`. It accepts one message symbol per cycle under a valid/ready handshake and forwards MSG_LEN message symbols unchanged. It then appends PAR_LEN parity symbols computed by an LFSR, with framing markers on the output. It sits between the framer and the channel serializer.

## Interface
- EGF_ORDER, 4, symbol width in bits (field GF(2^EGF_ORDER))
- EGF_POLY, 5'b10011, primitive polynomial, EGF_ORDER+1 bits (x^4+x+1)
- MSG_LEN, 4, message symbols per codeword, ≥1
- PAR_LEN, 2, parity symbols per codeword, ≥1; MSG_LEN+PAR_LEN ≤ 2^EGF_ORDER−1
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  EGF_ORDER  message symbol
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder accepts in_data this cycle
- out_data  output  EGF_ORDER  codeword symbol
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_first  output  1  out_data is codeword symbol 0
- out_last  output  1  out_data is final parity symbol

## Operation
- Generator g(x) = ∏_{i=0}^{PAR_LEN−1}(x − α^i), with α = 2. The leading coefficient is implicit 1. Coefficients g[0..PAR_LEN−1] are elaboration-time constants computed by a package function.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- The output register is free when !out_valid || out_ready.
- States:
  - MSG: in_ready = free. On an input transfer:
    - load in_data into the output register;
    - fb = in_data ^ par[PAR_LEN−1];
    - par[0] ← g[0]·fb, par[i] ← par[i−1] ^ g[i]·fb;
    - msg_cnt++.
    - On the MSG_LEN-th transfer, go to PAR and clear msg_cnt.
  - PAR: in_ready = 0. When free:
    - load par[PAR_LEN−1] into the output register;
    - shift par up by one, with 0 entering par[0];
    - par_cnt++.
    - On the PAR_LEN-th load, go to MSG and clear par_cnt. The LFSR is now all-zero.
- out_first is set with the load of message symbol 0. out_last is set with the load of the final parity symbol. Both travel with out_data.
- The output register holds data, valid and markers stable while out_valid && !out_ready.
- GF multiply is by constant only: a polynomial product reduced modulo EGF_POLY, purely combinational.
- Counters are $clog2(MSG_LEN+1) and $clog2(PAR_LEN+1) bits wide. Neither counter wraps except through the state transition.

## Timing
- Reset values: state MSG, par all 0, both counters 0, out_valid 0, out_data 0, out_first 0, out_last 0. in_ready is 1 the cycle after rst deasserts.
- Latency: an input transfer at edge t presents the symbol on out_data after t. The first parity symbol is valid one cycle after the last message symbol is loaded.
- With out_ready held at 1 and in_valid held at 1:
  - each codeword takes MSG_LEN+PAR_LEN cycles on the output, with no bubbles;
  - in_ready is low for exactly PAR_LEN cycles per codeword.
- Back-pressure: when out_ready is 0 and out_valid is 1, in_ready is 0 and the LFSR and counters hold.
- in_ready is combinational from state, out_valid and out_ready. There is no path from in_valid to in_ready.
- rst mid-codeword discards the partial codeword. out_valid drops to 0 on the next edge and the next accepted symbol is symbol 0.
- rst has priority over all transfers in the same cycle.

## Structure
- Package `rs_pkg`:
  - EGF_ORDER and EGF_POLY defaults;
  - symbol typedef;
  - function gf_mul(a, b, poly);
  - function gen_poly(PAR_LEN) returning the coefficient array;
  - state enum {MSG, PAR}.
- Sub-module `gf_const_mul`: multiplies by an elaboration-time constant, one instance per generator tap.
- All remaining logic lives in rs_stream_encoder: FSM, LFSR, counters and output register.

## Test plan
- Message 0,0,0,1 with out_ready=1 → out_data sequence 0,0,0,1,3,2. out_first is high on the first symbol and out_last on the symbol 2.
- Message 0,0,1,0 → parity 7,6. Message 0,0,1,1 → parity 4,4, which checks linearity.
- Three back-to-back codewords, in_valid=1, out_ready=1:
  - output is continuous for 18 cycles;
  - in_ready is low exactly 2 of every 6 cycles.
- Random out_ready stalls (50%) during message 0,0,1,1:
  - out_data, out_first and out_last are stable while stalled;
  - the final sequence is still 0,0,1,1,4,4.
- rst pulsed after 2 message symbols → out_valid is 0 the next cycle. The following message 0,0,0,1 yields 0,0,0,1,3,2.
- Reset check: after rst, all outputs are 0 and in_ready=1 while rst is low.
